bcd_countdown_timer: RTL

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with IDLE/RUN/PAUSE/DONE control and a tick prescaler.
// Define AUTO_RELOAD_EN to restart from the last loaded value at terminal count instead of stopping.
module bcd_countdown_timer #(
   parameter int TICK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] count,
   output logic       busy,
   output logic       done,
   output logic       zero,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] presc_q, presc_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
`ifdef AUTO_RELOAD_EN
   logic [7:0] reload_q, reload_d;
`endif

   logic [7:0] load_bcd;
   logic       tick;
   logic       terminal;
   logic       start_ok;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // Only called with a nonzero BCD value, so the tens borrow never underflows.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] != 4'd0) r = {v[7:4], v[3:0] - 4'd1};
      else                r = {v[7:4] - 4'd1, 4'd9};
      return r;
   endfunction

   assign load_bcd = {clamp_digit(load_val[7:4]), clamp_digit(load_val[3:0])};
   assign tick     = (presc_q == PRESC_MAX);
   assign terminal = (count_q == 8'h01);
   assign start_ok = start && !pause && (count_q != 8'h00);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      presc_d  = presc_q;
      done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      if (load && (state_q != RUN)) begin
         count_d  = load_bcd;
         presc_d  = 8'd0;
         state_d  = IDLE;
`ifdef AUTO_RELOAD_EN
         reload_d = load_bcd;
`endif
      end else begin
         case (state_q)
            IDLE, PAUSE: begin
               if (start_ok) state_d = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  presc_d = 8'd0;
                  if (terminal) begin
`ifdef AUTO_RELOAD_EN
                     count_d = reload_q;
`else
                     count_d = 8'h00;
                     state_d = DONE;
`endif
                     // Guarantees done never stays high across back-to-back terminal ticks.
                     done_d = !done_q;
                  end else begin
                     count_d = bcd_dec(count_q);
                  end
               end else begin
                  presc_d = presc_q + 8'd1;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= 8'h00;
         presc_q  <= 8'd0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload_q <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
`ifdef AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign zero      = (count_q == 8'h00);
   assign dbg_state = state_q;

endmodule
